// File: rtl/keypad_pkg.sv
// Shared constants, scan FSM state encoding and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned KP_ROWS   = 4;
   localparam int unsigned KP_COLS   = 4;
   localparam int unsigned KP_KEYS   = KP_ROWS * KP_COLS;
   localparam int unsigned KP_CODE_W = $clog2(KP_KEYS);
   localparam int unsigned KP_COL_W  = $clog2(KP_COLS);

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StSample,
      StFrame
   } kp_state_e;

   // Index of the lowest set bit; zero when no bit is set.
   function automatic logic [KP_CODE_W-1:0] lowest_set(input logic [KP_KEYS-1:0] bits);
      logic [KP_CODE_W-1:0] idx;
      idx = '0;
      for (int i = KP_KEYS - 1; i >= 0; i--) begin
         if (bits[i]) idx = KP_CODE_W'(i);
      end
      return idx;
   endfunction

   // Active-low one-cold column drive pattern.
   function automatic logic [KP_COLS-1:0] col_drive(input logic [KP_COL_W-1:0] c);
      return ~(KP_COLS'(1) << c);
   endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan-rate divider: one-cycle tick strobe every SCAN_DIV clock cycles.
module keypad_scan_tick #(
   parameter int unsigned SCAN_DIV = 25000
) (
   input  logic CLK,
   input  logic reset,
   output logic tick
);

   localparam int unsigned     DivW    = $clog2(SCAN_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

   logic [DivW-1:0] div_q;

   assign tick = (div_q == DivLast);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DivW'(1);
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad matrix scanner: column drive, row sampling, frame debounce and key events.
// Auto-repeat of the last reported key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 25000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned REPEAT_FRAMES  = 40
) (
   input  logic                 CLK,
   input  logic                 reset,
   output logic [KP_COLS-1:0]   col_out,
   input  logic [KP_ROWS-1:0]   row_in,
   output logic                 key_valid,
   output logic [KP_CODE_W-1:0] key_code,
   output logic [KP_KEYS-1:0]   key_map,
   output logic                 key_held
);

   localparam int unsigned         StableW   = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [StableW-1:0]  StableMax = StableW'(DEBOUNCE_SCANS);
   localparam logic [KP_COL_W-1:0] LastCol   = KP_COL_W'(KP_COLS - 1);

   if (SCAN_DIV < 2) begin : g_chk_scan_div
      $error("SCAN_DIV must be at least 2");
   end
   if (DEBOUNCE_SCANS < 1) begin : g_chk_debounce
      $error("DEBOUNCE_SCANS must be at least 1");
   end
   if (REPEAT_FRAMES < 1) begin : g_chk_repeat
      $error("REPEAT_FRAMES must be at least 1");
   end

   logic [1:0]          rst_pipe_q;
   logic                rst_sync_n;
   logic [KP_ROWS-1:0]  row_meta_q;
   logic [KP_ROWS-1:0]  row_sync_q;
   logic                tick;
   kp_state_e           state_q;
   logic [KP_COL_W-1:0] col_q;
   logic [KP_COL_W-1:0] col_next;
   logic [KP_KEYS-1:0]  raw_q;
   logic [KP_KEYS-1:0]  raw_sampled;
   logic [KP_KEYS-1:0]  prev_q;
   logic [StableW-1:0]  stable_q;
   logic                frame_done_q;
   logic                map_update;
   logic                press_event;
   logic [KP_KEYS-1:0]  new_keys;
   logic                rep_fire;

   // Reset asserts asynchronously but is released on a clock edge.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         rst_pipe_q <= '0;
      end else begin
         rst_pipe_q <= {rst_pipe_q[0], 1'b1};
      end
   end
   assign rst_sync_n = rst_pipe_q[1];

   always_ff @(posedge CLK or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         row_meta_q <= '1;
         row_sync_q <= '1;
      end else begin
         row_meta_q <= row_in;
         row_sync_q <= row_meta_q;
      end
   end

   keypad_scan_tick #(
      .SCAN_DIV(SCAN_DIV)
   ) u_scan_tick (
      .CLK  (CLK),
      .reset(rst_sync_n),
      .tick (tick)
   );

   assign col_next = col_q + KP_COL_W'(1);

   always_comb begin
      raw_sampled = raw_q;
      for (int r = 0; r < KP_ROWS; r++) begin
         raw_sampled[KP_CODE_W'(r * KP_COLS) + KP_CODE_W'(col_q)] = ~row_sync_q[r];
      end
   end

   always_ff @(posedge CLK or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q      <= StIdle;
         col_q        <= '0;
         col_out      <= '1;
         raw_q        <= '0;
         prev_q       <= '0;
         stable_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (tick) begin
            unique case (state_q)
               StIdle: begin
                  state_q <= StDrive;
                  col_out <= col_drive(col_q);
               end
               StDrive: begin
                  state_q <= StSample;
               end
               StSample: begin
                  raw_q <= raw_sampled;
                  if (col_q == LastCol) begin
                     state_q <= StFrame;
                     col_q   <= '0;
                     col_out <= '1;
                  end else begin
                     state_q <= StDrive;
                     col_q   <= col_next;
                     col_out <= col_drive(col_next);
                  end
               end
               StFrame: begin
                  if (raw_q == prev_q) begin
                     if (stable_q != StableMax) stable_q <= stable_q + StableW'(1);
                  end else begin
                     stable_q <= '0;
                  end
                  prev_q       <= raw_q;
                  frame_done_q <= 1'b1;
                  state_q      <= StDrive;
                  col_out      <= col_drive(col_q);
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   // Evaluated once per frame, the cycle after the debounce counter settles.
   assign map_update  = frame_done_q && (stable_q == StableMax) && (raw_q != key_map);
   assign new_keys    = raw_q & ~key_map;
   assign press_event = map_update && (|new_keys);

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned     RepW    = $clog2(REPEAT_FRAMES + 1);
   localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_FRAMES - 1);

   logic [RepW-1:0]    rep_q;
   logic [KP_KEYS-1:0] map_next;
   logic               code_held;

   assign map_next  = map_update ? raw_q : key_map;
   assign code_held = map_next[key_code];
   assign rep_fire  = frame_done_q && !press_event && code_held && (rep_q == RepLast);

   always_ff @(posedge CLK or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rep_q <= '0;
      end else if (frame_done_q) begin
         if (press_event || !code_held || rep_fire) begin
            rep_q <= '0;
         end else begin
            rep_q <= rep_q + RepW'(1);
         end
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge CLK or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         key_map   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         key_valid <= press_event || rep_fire;
         if (map_update) key_map <= raw_q;
         if (press_event) key_code <= lowest_set(new_keys);
      end
   end

   assign key_held = |key_map;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: directed scenarios plus random key patterns
// against a frame-level model of debounce, press events and (optionally) auto-repeat.
module tb_keypad_matrix_scanner;

   localparam int DEB = 2;
   localparam int REP = 4;
`ifdef KEYPAD_REPEAT_EN
   localparam int EXP_EXTRA = 3;
`else
   localparam int EXP_EXTRA = 0;
`endif

   logic        CLK;
   logic        reset;
   logic [3:0]  col_out;
   logic [3:0]  row_in;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] key_map;
   logic        key_held;
   logic [15:0] pressed;

   int cmp_n  = 0;
   int fail_n = 0;
   int pulse_tally = 0;

   logic [3:0]  ev_q[$];
   logic [3:0]  exp_q[$];
   logic [15:0] hist[$];
   logic [15:0] m_map;
   logic [3:0]  m_code;
   int          m_since;

   keypad_matrix_scanner #(
      .SCAN_DIV      (2),
      .DEBOUNCE_SCANS(DEB),
      .REPEAT_FRAMES (REP)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .col_out  (col_out),
      .row_in   (row_in),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_map  (key_map),
      .key_held (key_held)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Keypad: a pressed key shorts its row to the currently driven (low) column.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      if (key_valid) ev_q.push_back(key_code);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_n++;
      assert (obs === exp) else begin
         fail_n++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      hist.delete();
      hist.push_back(16'h0000);
      m_map   = '0;
      m_code  = '0;
      m_since = 0;
      exp_q.delete();
   endtask

   // Frame-level reference: the map follows raw once DEB+1 consecutive frames agree.
   task automatic model_step(input logic [15:0] keys);
      logic [15:0] fresh;
      bit          same;
      bit          evt;
      hist.push_back(keys);
      if (hist.size() > DEB + 1) void'(hist.pop_front());
      same = (hist.size() == DEB + 1);
      foreach (hist[i]) if (hist[i] != keys) same = 1'b0;
      exp_q.delete();
      evt = 1'b0;
      if (same && keys != m_map) begin
         fresh = keys & ~m_map;
         m_map = keys;
         if (fresh != 0) begin
            for (int i = 0; i < 16; i++) begin
               if (fresh[i]) begin
                  m_code = 4'(i);
                  break;
               end
            end
            exp_q.push_back(m_code);
            evt = 1'b1;
            m_since = 0;
         end
      end
`ifdef KEYPAD_REPEAT_EN
      if (!evt) begin
         if (m_map[m_code]) begin
            m_since++;
            if (m_since % REP == 0) exp_q.push_back(m_code);
         end else begin
            m_since = 0;
         end
      end
`endif
   endtask

   task automatic check_prev();
      chk("key_map", {16'h0, key_map}, {16'h0, m_map});
      chk("key_held", {31'h0, key_held}, {31'h0, (m_map != 0)});
      chk("key_code", {28'h0, key_code}, {28'h0, m_code});
      chk("pulse_count", ev_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         chk("pulse_code", {28'h0, ev_q[i]}, {28'h0, exp_q[i]});
      end
      pulse_tally += ev_q.size();
      ev_q.delete();
   endtask

   task automatic wait_frame(output bit ok);
      logic [3:0] last;
      last = col_out;
      ok   = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (col_out == 4'hF && last != 4'hF) begin
            ok = 1'b1;
            break;
         end
         last = col_out;
      end
   endtask

   task automatic wait_drive(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (col_out != 4'hF) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Apply keys for one whole frame; check the previous frame's outcome at its end.
   task automatic run_frame(input logic [15:0] keys);
      bit ok;
      pressed = keys;
      wait_frame(ok);
      chk("frame_seen", {31'h0, ok}, 32'h1);
      check_prev();
      model_step(keys);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " col_out"}, {28'h0, col_out}, 32'hF);
      chk({tag, " key_valid"}, {31'h0, key_valid}, 32'h0);
      chk({tag, " key_code"}, {28'h0, key_code}, 32'h0);
      chk({tag, " key_map"}, {16'h0, key_map}, 32'h0);
      chk({tag, " key_held"}, {31'h0, key_held}, 32'h0);
   endtask

   initial begin
      bit          ok;
      int          tally0;
      int          sel;
      int          hold;
      logic [15:0] pat;

      reset   = 1'b0;
      pressed = '0;
      reset_model();
      repeat (4) @(negedge CLK);
      check_reset_values("reset");
      reset = 1'b1;
      wait_drive(ok);
      chk("first_drive_seen", {31'h0, ok}, 32'h1);
      chk("first_drive col_out", {28'h0, col_out}, 32'hE);
      wait_frame(ok);
      chk("frame_seen", {31'h0, ok}, 32'h1);
      model_step(16'h0000);

      // Hold key 9: one event, then auto-repeat while held.
      for (int f = 0; f < 4; f++) run_frame(16'h0200);
      chk("t2 key_map", {16'h0, key_map}, 32'h0200);
      chk("t2 key_held", {31'h0, key_held}, 32'h1);
      chk("t2 key_code", {28'h0, key_code}, 32'h9);
      tally0 = pulse_tally;
      for (int f = 0; f < 12; f++) run_frame(16'h0200);
      run_frame(16'h0000);
      chk("t6 extra pulses", pulse_tally - tally0, EXP_EXTRA);

      // Release: map clears after debounce, no pulse, code held.
      tally0 = pulse_tally;
      for (int f = 0; f < 4; f++) run_frame(16'h0000);
      chk("t5 key_map", {16'h0, key_map}, 32'h0);
      chk("t5 key_held", {31'h0, key_held}, 32'h0);
      chk("t5 key_code", {28'h0, key_code}, 32'h9);
      chk("t5 no pulse", pulse_tally - tally0, 0);

      // Bouncing key never qualifies.
      tally0 = pulse_tally;
      for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? 16'h0200 : 16'h0000);
      run_frame(16'h0000);
      chk("t3 key_map", {16'h0, key_map}, 32'h0);
      chk("t3 no pulse", pulse_tally - tally0, 0);

      // Two keys in one frame: single event with the lower code.
      tally0 = pulse_tally;
      for (int f = 0; f < 4; f++) run_frame(16'h0028);
      chk("t4 key_map", {16'h0, key_map}, 32'h0028);
      chk("t4 key_code", {28'h0, key_code}, 32'h3);
      chk("t4 one pulse", pulse_tally - tally0, 1);
      for (int f = 0; f < 4; f++) run_frame(16'h0000);

      for (int blk = 0; blk < 12; blk++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       pat = 16'h0000;
            1:       pat = 16'h0001 << $urandom_range(0, 15);
            2:       pat = 16'($urandom) & 16'($urandom);
            default: pat = 16'($urandom);
         endcase
         hold = $urandom_range(1, 5);
         for (int f = 0; f < hold; f++) run_frame(pat);
      end

      // Reset in the middle of a frame with key 9 held.
      for (int f = 0; f < 4; f++) run_frame(16'h0200);
      chk("pre-reset key_map", {16'h0, key_map}, 32'h0200);
      repeat (7) @(negedge CLK);
      reset = 1'b0;
      #1;
      check_reset_values("mid-frame reset");
      ev_q.delete();
      reset_model();
      repeat (3) @(negedge CLK);
      chk("reset hold col_out", {28'h0, col_out}, 32'hF);
      reset = 1'b1;
      wait_drive(ok);
      chk("t1 drive_seen", {31'h0, ok}, 32'h1);
      chk("t1 first drive col_out", {28'h0, col_out}, 32'hE);
      wait_frame(ok);
      chk("frame_seen", {31'h0, ok}, 32'h1);
      model_step(16'h0200);
      for (int f = 0; f < 4; f++) run_frame(16'h0200);
      chk("post-reset key_map", {16'h0, key_map}, 32'h0200);
      chk("post-reset key_code", {28'h0, key_code}, 32'h9);
      for (int f = 0; f < 4; f++) run_frame(16'h0000);
      chk("final key_map", {16'h0, key_map}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule
